mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control unit for the next-generation MIPS core: a Moore state machine that sequences one instruction over 3–5+ cycles through a shared instruction/data memory, replacing the single-cycle combinational decoder. Sits between the instruction register (op/funct) and the multicycle datapath. Adds a ready-based memory handshake with wait states, a parametrised wait-timeout counter, and a sticky trap on illegal opcodes.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready cycles in a memory state before trapping; ≥1.
- TIMEOUT_W, $clog2(MEM_TIMEOUT+1): wait-counter width; derived, not overridden.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26] from instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU result == 0.
- gt  in  1  datapath signed rs > rt flag.
- mem_ready  in  1  memory completes current access this cycle.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- memread / memwrite  out  1 each  memory strobes.
- irwrite  out  1  load instruction register.
- pcen  out  1  PC write enable (pcwrite | taken branch).
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alusrca  out  1  0 = PC, 1 = rs.
- alusrcb  out  2  00 rt, 01 constant 4, 10 signimm, 11 signimm<<2.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sltu.
- regdst, memtoreg, regwrite  out  1 each  register-file write control.
- state  out  4  current state encoding (debug).
- bad_op  out  1  sticky: illegal opcode decoded.
- mem_timeout  out  1  sticky: memory wait timeout.

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, IMMEX 10, IMMWB 11, JUMP 12, TRAP 15.
- IDLE: all controls 0; → FETCH unconditionally.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00; irwrite and pcen asserted only in the cycle mem_ready=1; stay while mem_ready=0.
- DECODE: alusrca=0, alusrcb=11, add (branch target → ALUOut). op 000000→EXEC; 100011/101011→MEMADR; 000100/000101/010101→BRANCH; 001000/001100→IMMEX; 000010→JUMP; other→TRAP with bad_op set.
- MEMADR: alusrca=1, alusrcb=10, add; LW→MEMRD, SW→MEMWR.
- MEMRD: iord=1, memread=1; wait on mem_ready, then → MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1 held until mem_ready; → FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 101011 sltu); unknown funct → TRAP, bad_op set. ALUWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen = (BEQ & zero) | (BNE & ~zero) | (BGT & gt); → FETCH.
- IMMEX: alusrca=1, alusrcb=10; ADDI add, ANDI and. IMMWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JUMP: pcsrc=10, pcen=1 → FETCH.
- TRAP: all controls 0; held until reset.
- Unlisted controls are 0 in every state.

## Timing
- Reset: state=IDLE, counter 0, bad_op=0, mem_timeout=0; all control outputs 0. Reset asserted mid-access aborts immediately; memwrite drops asynchronously.
- Zero-wait latency in cycles (FETCH→FETCH): LW 5, SW 4, R-type 4, ADDI/ANDI 4, branch 3, J 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- Wait counter clears on entry to any memory state; increments each cycle there with mem_ready=0.
- Counter reaching MEM_TIMEOUT → next state TRAP, mem_timeout set. mem_ready=1 in the same cycle wins: access completes normally.
- Outputs purely state-decoded except irwrite/pcen (qualified by mem_ready, zero, gt, op).

## Configuration
- MEM_TIMEOUT_EN defined: wait counter and timeout trap present as above.
- Undefined: no counter; memory states wait indefinitely; mem_timeout tied 0; MEM_TIMEOUT ignored.

## Test plan
- Reset low then high, mem_ready=1, LW (op 100011) → state 0,1,2,3,4,5,1; regwrite=1 with memtoreg=1 only in MEMWB.
- SW with mem_ready low 3 cycles in MEMWR → memwrite held 4 cycles, then FETCH; 7 cycles total.
- BNE with zero=0 → pcen=1, pcsrc=01 in BRANCH; zero=1 → pcen=0. BGT with gt=1 → pcen=1.
- op 111111 → TRAP after DECODE, bad_op=1, all strobes 0 until reset; reset clears bad_op.
- MEM_TIMEOUT_EN, MEM_TIMEOUT=4, mem_ready=0 in FETCH → TRAP after 4 wait cycles, mem_timeout=1; mem_ready=1 on 4th cycle → normal DECODE.
- Reset asserted during MEMWR with memwrite=1 → memwrite=0 without clock edge, state=0.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields, datapath flags, memory handshake,
// control strobes and status. The controller is the master, the datapath the slave.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       gt;
    logic       mem_ready;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] state;
    logic       bad_op;
    logic       mem_timeout;

    modport master (
        input  op, funct, zero, gt, mem_ready,
        output iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, state, bad_op, mem_timeout
    );

    modport slave (
        output op, funct, zero, gt, mem_ready,
        input  iord, memread, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, state, bad_op, mem_timeout
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with ready-based shared-memory handshake and sticky traps.
// Define MEM_TIMEOUT_EN to add the memory wait counter and the timeout trap.
module mips_mc_controller #(
    parameter  int MEM_TIMEOUT = 16,
    localparam int TIMEOUT_W   = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGT   = 6'b010101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_SLTU = 3'b011;

    // fetch/jump/branch are internal qualifiers for the two non-Moore outputs
    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       fetch;
        logic       jump;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

    function automatic logic funct_known(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010, 6'b101011: funct_known = 1'b1;
            default:                         funct_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            6'b101011: funct_alu = ALU_SLTU;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    function automatic ctrl_t ctrl_decode(input state_e s, input logic [5:0] op_v,
                                          input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            S_IDLE: c = '0;
            S_FETCH: begin
                c.memread    = 1'b1;
                c.fetch      = 1'b1;
                c.alusrcb    = 2'b01;
                c.alucontrol = ALU_ADD;
            end
            S_DECODE: begin
                c.alusrcb    = 2'b11;
                c.alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXEC: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b00;
                c.alucontrol = funct_alu(f);
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b00;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
            end
            S_IMMEX: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b10;
                c.alucontrol = (op_v == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            S_IMMWB: c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc = 2'b10;
                c.jump  = 1'b1;
            end
            S_TRAP:  c = '0;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    logic   bad_op_q;
    logic   wait_hit_s;
    logic   taken_s;

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] wait_cnt_q;
    logic                 mem_timeout_q;
    logic                 mem_state_s;

    assign mem_state_s     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // This cycle is the MEM_TIMEOUT-th consecutive wait; ready still wins
    assign wait_hit_s      = (wait_cnt_q == WAIT_LAST);
    assign bus.mem_timeout = mem_timeout_q;
`else
    assign wait_hit_s      = 1'b0;
    assign bus.mem_timeout = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_hit_s) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:              state_d = S_EXEC;
                    OP_LW, OP_SW:          state_d = S_MEMADR;
                    OP_BEQ, OP_BNE, OP_BGT: state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI:      state_d = S_IMMEX;
                    OP_J:                  state_d = S_JUMP;
                    default:               state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_hit_s) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_hit_s) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                if (funct_known(bus.funct)) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_IMMEX: state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Branch condition from the IR opcode and the datapath flags
    always_comb begin
        case (bus.op)
            OP_BEQ:  taken_s = bus.zero;
            OP_BNE:  taken_s = ~bus.zero;
            OP_BGT:  taken_s = bus.gt;
            default: taken_s = 1'b0;
        endcase
    end

    // State, control word registered for the state being entered, sticky status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            bad_op_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_decode(state_d, bus.op, bus.funct);
            // Only DECODE and EXEC reach TRAP on an illegal encoding
            if ((state_d == S_TRAP) && ((state_q == S_DECODE) || (state_q == S_EXEC))) begin
                bad_op_q <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (mem_state_s && !bus.mem_ready) begin
                wait_cnt_q <= wait_cnt_q + TIMEOUT_W'(1);
            end
            if ((state_d == S_TRAP) && mem_state_s) begin
                mem_timeout_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.iord       = ctrl_q.iord;
    assign bus.memread    = ctrl_q.memread;
    assign bus.memwrite   = ctrl_q.memwrite;
    assign bus.pcsrc      = ctrl_q.pcsrc;
    assign bus.alusrca    = ctrl_q.alusrca;
    assign bus.alusrcb    = ctrl_q.alusrcb;
    assign bus.alucontrol = ctrl_q.alucontrol;
    assign bus.regdst     = ctrl_q.regdst;
    assign bus.memtoreg   = ctrl_q.memtoreg;
    assign bus.regwrite   = ctrl_q.regwrite;
    assign bus.irwrite    = ctrl_q.fetch & bus.mem_ready;
    assign bus.pcen       = (ctrl_q.fetch & bus.mem_ready) | ctrl_q.jump | (ctrl_q.branch & taken_s);
    assign bus.state      = state_q;
    assign bus.bad_op     = bad_op_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: instruction table plus hand-written
// wait-state, trap, timeout and asynchronous-reset sequences, compared via a scoreboard.
module tb_mips_mc_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_mc_controller_if bus ();

    mips_mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        gt;
        int          n;
        logic [23:0] seq;
        logic [2:0]  alu;
        logic        taken;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        bo;
        logic        mt;
        bit          chk;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_funct = 6'd0;
    logic       cur_zero = 1'b0;
    logic       cur_gt = 1'b0;
    logic [2:0] cur_alu = 3'b010;
    logic       cur_taken = 1'b0;

    // {iord,memread,memwrite,irwrite,pcen,pcsrc,alusrca,alusrcb,alucontrol,regdst,memtoreg,regwrite}
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic [2:0] alu,
                                            input logic taken, input logic rdy);
        case (st)
            4'd1:    exp_ctl = {1'b0, 1'b1, 1'b0, rdy, rdy, 2'b00, 1'b0, 2'b01, 3'b010, 3'b000};
            4'd2:    exp_ctl = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 3'b000};
            4'd3:    exp_ctl = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 3'b000};
            4'd4:    exp_ctl = {1'b1, 1'b1, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000};
            4'd5:    exp_ctl = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b011};
            4'd6:    exp_ctl = {1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 3'b000};
            4'd7:    exp_ctl = {5'b00000, 2'b00, 1'b1, 2'b00, alu, 3'b000};
            4'd8:    exp_ctl = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b101};
            4'd9:    exp_ctl = {4'b0000, taken, 2'b01, 1'b1, 2'b00, 3'b110, 3'b000};
            4'd10:   exp_ctl = {5'b00000, 2'b00, 1'b1, 2'b10, alu, 3'b000};
            4'd11:   exp_ctl = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 3'b001};
            4'd12:   exp_ctl = {4'b0000, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 3'b000};
            default: exp_ctl = 16'h0000;
        endcase
    endfunction

    task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] funct,
                           input logic zero, input logic gt, input int n,
                           input logic [23:0] seq, input logic [2:0] alu, input logic taken);
        vec_t v;
        v.name = nm; v.op = op; v.funct = funct; v.zero = zero; v.gt = gt;
        v.n = n; v.seq = seq; v.alu = alu; v.taken = taken;
        tbl.push_back(v);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [15:0] got_ctl;
        got_ctl = {bus.iord, bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                   bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regdst, bus.memtoreg,
                   bus.regwrite};
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if ((bus.state !== e.st) || (bus.bad_op !== e.bo) || (bus.mem_timeout !== e.mt) ||
                (e.chk && (got_ctl !== e.ctl))) begin
                n_err++;
                $display("FAIL %s: got state=%0d ctl=%h bad_op=%b mem_timeout=%b, want state=%0d ctl=%h bad_op=%b mem_timeout=%b",
                         e.name, bus.state, got_ctl, bus.bad_op, bus.mem_timeout,
                         e.st, e.ctl, e.bo, e.mt);
            end
        end
    endtask

    task automatic push_exp(input string nm, input logic [3:0] st, input logic [15:0] ctl,
                            input logic bo, input logic mt, input bit chk);
        exp_t e;
        e.name = nm; e.st = st; e.ctl = ctl; e.bo = bo; e.mt = mt; e.chk = chk;
        sb_q.push_back(e);
    endtask

    // One clock: drive inputs on the falling edge, queue the expectation, check 1 ns later
    task automatic cyc(input string nm, input logic rdy, input logic [3:0] st,
                       input logic bo, input logic mt, input bit chk);
        @(negedge clk);
        bus.op = cur_op; bus.funct = cur_funct; bus.zero = cur_zero; bus.gt = cur_gt;
        bus.mem_ready = rdy;
        push_exp(nm, st, exp_ctl(st, cur_alu, cur_taken, rdy), bo, mt, chk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_exp(nm, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check_out();
        #1 reset = 1'b1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] funct,
                             input logic [2:0] alu, input logic taken);
        cur_op = op; cur_funct = funct; cur_zero = 1'b0; cur_gt = 1'b0;
        cur_alu = alu; cur_taken = taken;
    endtask

    initial begin
        reset = 1'b0;
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.gt = 1'b0; bus.mem_ready = 1'b1;

        add_vec("lw",        6'b100011, 6'b000000, 1'b0, 1'b0, 5, 24'h054321, 3'b010, 1'b0);
        add_vec("sw",        6'b101011, 6'b000000, 1'b0, 1'b0, 4, 24'h006321, 3'b010, 1'b0);
        add_vec("r_add",     6'b000000, 6'b100000, 1'b0, 1'b0, 4, 24'h008721, 3'b010, 1'b0);
        add_vec("r_sub",     6'b000000, 6'b100010, 1'b0, 1'b0, 4, 24'h008721, 3'b110, 1'b0);
        add_vec("r_and",     6'b000000, 6'b100100, 1'b0, 1'b0, 4, 24'h008721, 3'b000, 1'b0);
        add_vec("r_or",      6'b000000, 6'b100101, 1'b0, 1'b0, 4, 24'h008721, 3'b001, 1'b0);
        add_vec("r_slt",     6'b000000, 6'b101010, 1'b0, 1'b0, 4, 24'h008721, 3'b111, 1'b0);
        add_vec("r_sltu",    6'b000000, 6'b101011, 1'b0, 1'b0, 4, 24'h008721, 3'b011, 1'b0);
        add_vec("addi",      6'b001000, 6'b000000, 1'b0, 1'b0, 4, 24'h00BA21, 3'b010, 1'b0);
        add_vec("andi",      6'b001100, 6'b000000, 1'b0, 1'b0, 4, 24'h00BA21, 3'b000, 1'b0);
        add_vec("beq_z1",    6'b000100, 6'b000000, 1'b1, 1'b0, 3, 24'h000921, 3'b110, 1'b1);
        add_vec("beq_z0",    6'b000100, 6'b000000, 1'b0, 1'b0, 3, 24'h000921, 3'b110, 1'b0);
        add_vec("beq_z0_gt", 6'b000100, 6'b000000, 1'b0, 1'b1, 3, 24'h000921, 3'b110, 1'b0);
        add_vec("bne_z0",    6'b000101, 6'b000000, 1'b0, 1'b0, 3, 24'h000921, 3'b110, 1'b1);
        add_vec("bne_z1",    6'b000101, 6'b000000, 1'b1, 1'b0, 3, 24'h000921, 3'b110, 1'b0);
        add_vec("bgt_gt1",   6'b010101, 6'b000000, 1'b0, 1'b1, 3, 24'h000921, 3'b110, 1'b1);
        add_vec("bgt_gt0",   6'b010101, 6'b000000, 1'b1, 1'b0, 3, 24'h000921, 3'b110, 1'b0);
        add_vec("j",         6'b000010, 6'b000000, 1'b0, 1'b0, 3, 24'h000C21, 3'b010, 1'b0);

        do_reset("reset_idle");

        foreach (tbl[k]) begin
            cur_op = tbl[k].op; cur_funct = tbl[k].funct;
            cur_zero = tbl[k].zero; cur_gt = tbl[k].gt;
            cur_alu = tbl[k].alu; cur_taken = tbl[k].taken;
            for (int i = 0; i < tbl[k].n; i++) begin
                cyc(tbl[k].name, 1'b1, tbl[k].seq[4*i +: 4], 1'b0, 1'b0, 1'b1);
            end
        end

        // SW with three wait cycles in MEMWR: memwrite held four cycles, seven in total
        set_instr(6'b101011, 6'b000000, 3'b010, 1'b0);
        cyc("sw_wait_fetch",  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("sw_wait_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("sw_wait_memadr", 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("sw_wait_memwr", 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        cyc("sw_wait_memwr_done", 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);

        // LW with wait states in both FETCH and MEMRD
        set_instr(6'b100011, 6'b000000, 3'b010, 1'b0);
        cyc("lw_wait_fetch", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_fetch", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_fetch_done", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_memadr", 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_memrd", 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_memrd", 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_memrd_done", 1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc("lw_wait_memwb", 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);

        set_instr(6'b000010, 6'b000000, 3'b010, 1'b0);
`ifdef MEM_TIMEOUT_EN
        // Ready on the fourth wait cycle wins over the timeout
        for (int i = 0; i < 3; i++) cyc("to_fetch_wait", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("to_fetch_ready_last", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("to_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("to_jump",   1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("to_fetch_stall", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("to_trap", 1'b0, 4'd15, 1'b0, 1'b1, 1'b1);
        cyc("to_trap_hold", 1'b1, 4'd15, 1'b0, 1'b1, 1'b1);
        do_reset("to_reset_clears");
`else
        // Without the timeout feature FETCH waits indefinitely
        for (int i = 0; i < 20; i++) cyc("nt_fetch_wait", 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("nt_fetch_done", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("nt_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("nt_jump",   1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
`endif

        // Illegal opcode: TRAP with bad_op, everything quiet until reset
        set_instr(6'b111111, 6'b000000, 3'b010, 1'b0);
        cyc("badop_fetch",  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("badop_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("badop_trap",   1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        cyc("badop_trap",   1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
        cyc("badop_trap",   1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        do_reset("badop_reset_clears");

        // Unknown R-type funct traps out of EXEC
        set_instr(6'b000000, 6'b000000, 3'b010, 1'b0);
        cyc("badfn_fetch",  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("badfn_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("badfn_exec",   1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        cyc("badfn_trap",   1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        do_reset("badfn_reset_clears");

        // Reset mid-MEMWR drops memwrite without a clock edge
        set_instr(6'b101011, 6'b000000, 3'b010, 1'b0);
        cyc("rst_sw_fetch",  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("rst_sw_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("rst_sw_memadr", 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        cyc("rst_sw_memwr",  1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b0;
        #1;
        push_exp("rst_async_abort", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check_out();
        #1 reset = 1'b1;
        set_instr(6'b000010, 6'b000000, 3'b010, 1'b0);
        cyc("rst_rec_fetch",  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        cyc("rst_rec_decode", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        cyc("rst_rec_jump",   1'b1, 4'd12, 1'b0, 1'b0, 1'b1);

        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
